// File: rtl/bus_rr_arbiter.sv
// Two-master, two-slave shared-bus controller: round-robin arbitration
// without preemption, owner-to-bus mux, address decode, and read return.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   m0_* / m1_*           master request, write enable, address, write data
//   m0_grant, m1_grant    registered bus-ownership grants (never both)
//   m_din                 registered read data broadcast to both masters
//   s_wr, s_addr, s_din   shared-bus write enable, address, write data
//   s0_sel, s1_sel        slave selects (S0 memory, S1 factorial core)
//   s0_dout, s1_dout      slave read data, valid while selected for read
module bus_rr_arbiter #(
   parameter int                ADDR_W  = 16,
   parameter int                DATA_W  = 64,
   parameter logic [ADDR_W-1:0] S0_BASE = 16'h0000,
   parameter logic [ADDR_W-1:0] S0_MASK = 16'hF800,
   parameter logic [ADDR_W-1:0] S1_BASE = 16'h7000,
   parameter logic [ADDR_W-1:0] S1_MASK = 16'hFE00
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_dout,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_dout,
   output logic              m0_grant,
   output logic              m1_grant,
   output logic [DATA_W-1:0] m_din,
   output logic              s_wr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_din,
   output logic              s0_sel,
   output logic              s1_sel,
   input  logic [DATA_W-1:0] s0_dout,
   input  logic [DATA_W-1:0] s1_dout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      M0_OWN = 2'd1,
      M1_OWN = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   // 1 = master 1 owned the bus most recently
   logic last_m1;
   logic last_m1_nx;

   logic bus_busy;
   logic s0_hit;
   logic s1_hit;
   logic rd_s0;
   logic rd_s1;

   // ---------------- arbitration ----------------

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         last_m1 <= 1'b1;
      end else begin
         state   <= state_nx;
         last_m1 <= last_m1_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      last_m1_nx = last_m1;
      unique case (state)
         IDLE: begin
            if (m0_req && m1_req)
               state_nx = last_m1 ? M0_OWN : M1_OWN;
            else if (m0_req)
               state_nx = M0_OWN;
            else if (m1_req)
               state_nx = M1_OWN;
         end
         // Owner keeps the bus until it drops its request;
         // the waiting master then takes over with no idle gap.
         M0_OWN: begin
            if (!m0_req)
               state_nx = m1_req ? M1_OWN : IDLE;
         end
         M1_OWN: begin
            if (!m1_req)
               state_nx = m0_req ? M0_OWN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (state_nx == M0_OWN)
         last_m1_nx = 1'b0;
      else if (state_nx == M1_OWN)
         last_m1_nx = 1'b1;
   end

   assign m0_grant = (state == M0_OWN);
   assign m1_grant = (state == M1_OWN);
   assign bus_busy = (state != IDLE);

   // ---------------- bus mux ----------------

   always_comb begin
      s_wr   = 1'b0;
      s_addr = '0;
      s_din  = '0;
      unique case (state)
         M0_OWN: begin
            s_wr   = m0_wr;
            s_addr = m0_addr;
            s_din  = m0_dout;
         end
         M1_OWN: begin
            s_wr   = m1_wr;
            s_addr = m1_addr;
            s_din  = m1_dout;
         end
         default: begin
            s_wr   = 1'b0;
            s_addr = '0;
            s_din  = '0;
         end
      endcase
   end

   // ---------------- decode ----------------

   // Idle bus drives address 0, which would hit S0, so gate on ownership.
   assign s0_hit = ((s_addr & S0_MASK) == S0_BASE);
   assign s1_hit = ((s_addr & S1_MASK) == S1_BASE);
   assign s0_sel = bus_busy && s0_hit;
   assign s1_sel = bus_busy && s1_hit && !s0_hit;

   // ---------------- read return ----------------

   // Read flags and slave data are captured on the edge that closes the
   // address cycle, so m_din is valid in the following cycle, even when
   // the grant is dropped on that same edge.
   assign rd_s0 = s0_sel && !s_wr;
   assign rd_s1 = s1_sel && !s_wr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         m_din <= '0;
      else if (rd_s0)
         m_din <= s0_dout;
      else if (rd_s1)
         m_din <= s1_dout;
      else
         m_din <= '0;
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed testbench for bus_rr_arbiter: vector table plus hand sequences
// for no-preemption and asynchronous reset.
module tb_bus_rr_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        m0_req = 0, m0_wr = 0;
   logic [15:0] m0_addr = '0;
   logic [63:0] m0_dout = '0;
   logic        m1_req = 0, m1_wr = 0;
   logic [15:0] m1_addr = '0;
   logic [63:0] m1_dout = '0;
   logic        m0_grant, m1_grant;
   logic [63:0] m_din;
   logic        s_wr;
   logic [15:0] s_addr;
   logic [63:0] s_din;
   logic        s0_sel, s1_sel;
   logic [63:0] s0_dout = '0, s1_dout = '0;

   int n_chk = 0;
   int n_fail = 0;

   bus_rr_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_wr(m0_wr),
      .m0_addr(m0_addr), .m0_dout(m0_dout),
      .m1_req(m1_req), .m1_wr(m1_wr),
      .m1_addr(m1_addr), .m1_dout(m1_dout),
      .m0_grant(m0_grant), .m1_grant(m1_grant),
      .m_din(m_din),
      .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
      .s0_sel(s0_sel), .s1_sel(s1_sel),
      .s0_dout(s0_dout), .s1_dout(s1_dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m0_req, m0_wr;
      logic [15:0] m0_addr;
      logic [63:0] m0_dout;
      logic        m1_req, m1_wr;
      logic [15:0] m1_addr;
      logic [63:0] m1_dout, s0_dout, s1_dout;
      logic        e_g0, e_g1;
      logic [63:0] e_din;
      logic        e_wr;
      logic [15:0] e_addr;
      logic [63:0] e_sdin;
      logic        e_s0, e_s1;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input vec_t v);
      chk({tag, " m0_grant"}, 64'(m0_grant), 64'(v.e_g0));
      chk({tag, " m1_grant"}, 64'(m1_grant), 64'(v.e_g1));
      chk({tag, " m_din"}, m_din, v.e_din);
      chk({tag, " s_wr"}, 64'(s_wr), 64'(v.e_wr));
      chk({tag, " s_addr"}, 64'(s_addr), 64'(v.e_addr));
      chk({tag, " s_din"}, s_din, v.e_sdin);
      chk({tag, " s0_sel"}, 64'(s0_sel), 64'(v.e_s0));
      chk({tag, " s1_sel"}, 64'(s1_sel), 64'(v.e_s1));
   endtask

   initial begin
      // fields: m0 req,wr,addr,dout | m1 req,wr,addr,dout | s0_dout,s1_dout
      //   | exp g0,g1,m_din | s_wr,s_addr,s_din | s0_sel,s1_sel
      vecs.push_back('{0,0,'h0000,0, 0,0,'h0000,0, 0,0,
                       0,0,0, 0,'h0000,0, 0,0});
      vecs.push_back('{1,1,'h0010,5, 0,0,'h0000,0, 0,0,
                       1,0,0, 1,'h0010,5, 1,0});
      vecs.push_back('{1,0,'h0020,0, 1,0,'h7008,0, 'hAA,0,
                       1,0,'hAA, 0,'h0020,0, 1,0});
      vecs.push_back('{0,0,'h0020,0, 1,0,'h7008,0, 'hAA,120,
                       0,1,'hAA, 0,'h7008,0, 0,1});
      vecs.push_back('{0,0,'h0020,0, 1,0,'h7008,0, 'hAA,120,
                       0,1,120, 0,'h7008,0, 0,1});
      vecs.push_back('{0,0,'h0000,0, 1,1,'h4000,'h77, 'hAA,120,
                       0,1,0, 1,'h4000,'h77, 0,0});
      vecs.push_back('{0,0,'h0000,0, 1,0,'h4000,'h77, 'hAA,120,
                       0,1,0, 0,'h4000,'h77, 0,0});
      vecs.push_back('{0,0,'h0000,0, 0,0,'h4000,'h77, 'hAA,120,
                       0,0,0, 0,'h0000,0, 0,0});
      vecs.push_back('{1,0,'h0008,0, 1,1,'h7000,9, 'h33,120,
                       1,0,0, 0,'h0008,0, 1,0});
      vecs.push_back('{0,0,'h0008,0, 1,1,'h7000,9, 'h33,120,
                       0,1,'h33, 1,'h7000,9, 0,1});
      vecs.push_back('{0,0,'h0000,0, 0,1,'h7000,9, 'h33,120,
                       0,0,0, 0,'h0000,0, 0,0});
      vecs.push_back('{0,0,'h0000,0, 1,0,'h0100,0, 'h44,120,
                       0,1,0, 0,'h0100,0, 1,0});
      vecs.push_back('{1,0,'h7010,0, 1,0,'h0100,0, 'h44,120,
                       0,1,'h44, 0,'h0100,0, 1,0});
      vecs.push_back('{1,0,'h7010,0, 0,0,'h0100,0, 'h44,55,
                       1,0,'h44, 0,'h7010,0, 0,1});
      vecs.push_back('{0,0,'h7010,0, 0,0,'h0000,0, 'h44,55,
                       0,0,55, 0,'h0000,0, 0,0});
      vecs.push_back('{1,1,'h0001,1, 1,1,'h7001,2, 0,0,
                       0,1,0, 1,'h7001,2, 0,1});

      // reset
      #3 reset_n = 1'b0;
      #1;
      chk("rst m0_grant", 64'(m0_grant), 64'd0);
      chk("rst m1_grant", 64'(m1_grant), 64'd0);
      chk("rst m_din", m_din, 64'd0);
      chk("rst s_addr", 64'(s_addr), 64'd0);
      step();
      step();
      #2 reset_n = 1'b1;
      @(negedge clk);

      // table vectors
      foreach (vecs[i]) begin
         m0_req  = vecs[i].m0_req;
         m0_wr   = vecs[i].m0_wr;
         m0_addr = vecs[i].m0_addr;
         m0_dout = vecs[i].m0_dout;
         m1_req  = vecs[i].m1_req;
         m1_wr   = vecs[i].m1_wr;
         m1_addr = vecs[i].m1_addr;
         m1_dout = vecs[i].m1_dout;
         s0_dout = vecs[i].s0_dout;
         s1_dout = vecs[i].s1_dout;
         step();
         chk_all($sformatf("v%0d", i), vecs[i]);
      end

      // no preemption: m0 holds the bus 20 cycles while m1 waits
      m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
      step();
      chk("np idle", 64'({m0_grant, m1_grant}), 64'd0);
      m0_req = 1; m1_req = 1; m0_addr = 'h0010; m1_addr = 'h7008;
      step();
      chk("np first m0", 64'(m0_grant), 64'd1);
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("np hold%0d", k),
             64'({m0_grant, m1_grant}), 64'b10);
      end
      m0_req = 0;
      step();
      chk("np handover", 64'({m0_grant, m1_grant}), 64'b01);

      // async reset mid-read while m0 owns the bus
      m1_req = 0; m0_req = 1; m0_wr = 0;
      m0_addr = 'h0010; s0_dout = 'h99;
      step();
      chk("ar m0 own", 64'(m0_grant), 64'd1);
      step();
      chk("ar read", m_din, 64'h99);
      m0_wr = 1;
      #1;
      chk("ar s_wr pre", 64'(s_wr), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar g0", 64'(m0_grant), 64'd0);
      chk("ar g1", 64'(m1_grant), 64'd0);
      chk("ar m_din", m_din, 64'd0);
      chk("ar s_wr", 64'(s_wr), 64'd0);
      chk("ar s_addr", 64'(s_addr), 64'd0);
      m0_req = 0;
      #1 reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("post idle%0d", k),
             64'({m0_grant, m1_grant, s0_sel, s1_sel}), 64'd0);
         chk($sformatf("post s_addr%0d", k), 64'(s_addr), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
